data_ram_responder: RTL
=======================

Name: data_ram_responder

Overview:
- Responder end of the CPU load/store memory interface inside the minimal SOPC.
- The core issues word, halfword and byte requests. This block serves them from an internal word-organised RAM.
- Wait states are programmable. Completion is reported with a one-cycle ack, and a stall signal holds the MEM stage until then.
- It replaces the zero-latency data RAM, so the pipeline stall path can be exercised.

Parameters:
- ADDR_W, 10, word-address width; the RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and ack (0..15).
- INIT_FILE, "", optional $readmemh image. Empty means the contents are uninitialised.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low: asserting it forces reset state immediately, and release is synchronous to clk.
- mem_ce_i  input  1  request valid; held by the requester until ack.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address; bits [1:0] are ignored.
- mem_sel_i  input  4  byte enables, big-endian: sel[3] maps to data[31:24], sel[0] maps to data[7:0].
- mem_data_i  input  32  store data.
- mem_data_o  output  32  load data, valid while mem_ack_o=1.
- mem_ack_o  output  1  one-cycle completion pulse.
- mem_err_o  output  1  out-of-range flag, valid with ack.
- stall_o  output  1  combinational stall request to the pipeline control.

Behaviour:
- Reset values:
  - state = IDLE, wait counter = 0.
  - mem_data_o = 0, mem_ack_o = 0, mem_err_o = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - When mem_ce_i=1, latch we, addr, sel and data, and load the counter with WAIT_CYCLES.
  - Next state is ACK if WAIT_CYCLES=0, otherwise WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 and mem_ce_i is still 1, go to ACK.
  - If mem_ce_i drops to 0 in WAIT, abort to IDLE. No RAM write, no ack.
- ACK:
  - mem_ack_o=1 for exactly one cycle. Next state is always IDLE.
  - A new request can be accepted no earlier than the cycle after ACK, so there is one idle bubble between back-to-back requests.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- stall_o = mem_ce_i & ~mem_ack_o. It is 0 whenever mem_ce_i=0.
- Word index = latched addr[ADDR_W+1:2].
- Range check:
  - If latched addr[31:ADDR_W+2] is non-zero, the request is out of range.
  - Out-of-range requests still complete with ack, mem_err_o=1 and mem_data_o=0.
  - No write occurs.
- Store:
  - The RAM is written on the edge that enters ACK, using the latched data and sel per byte lane.
  - sel=0000 completes normally and writes nothing.
- Load:
  - mem_data_o is registered on the edge that enters ACK and carries the full 32-bit word.
  - Lane extraction and sign extension are done by the core.
- Outside ACK, mem_data_o holds 0 and mem_err_o holds 0.
- Request attributes that change after acceptance are ignored; the latched copy is used.
- Reset mid-operation: return to IDLE immediately and clear the outputs. An in-flight store is dropped, and the RAM is untouched unless the write edge had already occurred.
- Latched request fields need no reset.

Decomposition:
- Shared package/defines:
  - FSM state encodings (S_IDLE, S_WAIT, S_ACK).
  - Byte-lane select constants (SEL_WORD=4'b1111, SEL_HI_HALF=4'b1100, SEL_LO_HALF=4'b0011, and the single-byte codes).
  - Existing data-bus width constants.
- One natural sub-module, data_ram_bytelane: a 2^ADDR_W x 32 array with a 4-bit byte-write enable and a synchronous read port.
- The FSM, counter and range check stay in data_ram_responder.

Test Plan:
- Reset release with rst low until 195 ns, no requests:
  - All outputs 0 and stall_o=0.
  - Asserting rst low mid-WAIT immediately gives ack=0 and state IDLE.
- Word store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x00000010 with sel=1111: ack 3 cycles after accept, stall_o high for the 3 cycles before ack.
  - Then load 0x10: mem_data_o=0xDEADBEEF with ack, err=0.
- Byte store with sel=0010 and data 0x0000AB00 to 0x10: subsequent load returns 0xDEADABEF.
- WAIT_CYCLES=0:
  - Ack on the cycle after accept.
  - Two back-to-back loads are separated by one idle cycle.
- Abort: load accepted, mem_ce_i dropped after 1 wait cycle:
  - No ack, FSM IDLE.
  - For an aborted store, a later load shows the RAM unchanged.
- Out of range, ADDR_W=10, store to 0x00001000:
  - ack=1, err=1, data_o=0.
  - A load of word 0 shows it unmodified.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_responder_pkg
// Shared definitions for the data RAM responder and its RAM array:
//   - responder FSM state encoding
//   - byte-lane select codes (big-endian: sel[3] -> data[31:24])
//   - data-bus width constants
//   - address range helper
// -----------------------------------------------------------------------------
package data_ram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int CNT_W  = 4;            // wait-state counter, 0..15

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0] SEL_NONE    = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;
  localparam logic [SEL_W-1:0] SEL_HI_HALF = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_LO_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_BYTE3   = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_BYTE2   = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_BYTE1   = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_BYTE0   = 4'b0001;

  // A byte address is out of range when any bit above the word index is set.
  // A shift is used instead of a slice so ADDR_W up to 30 stays legal.
  function automatic logic addr_out_of_range(input logic [DATA_W-1:0] addr,
                                             input int                addr_w);
    return (addr >> (addr_w + 2)) != '0;
  endfunction

endpackage

// File: rtl/data_ram_bytelane.sv
// -----------------------------------------------------------------------------
// data_ram_bytelane
// Word-organised RAM, 2^ADDR_W x 32, with a per-byte write enable and a
// synchronous (registered) read port. Contents are not reset.
//
// Ports:
//   clk        system clock
//   wr_addr_i  word index for the write port
//   wr_be_i    byte write enables, wr_be_i[b] writes wr_data_i[8b+7:8b]
//   wr_data_i  write data
//   rd_addr_i  word index for the read port
//   rd_data_o  registered read data (old data on a same-address write)
// -----------------------------------------------------------------------------
module data_ram_bytelane
  import data_ram_responder_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [SEL_W-1:0]  wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (wr_be_i[b]) begin
        mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
// Responder side of the CPU load/store interface. Serves word/halfword/byte
// requests from an internal RAM with WAIT_CYCLES programmable wait states,
// a one-cycle ack, an out-of-range error flag and a stall request.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset (synchronous release)
//   mem_ce_i    request valid, held until ack
//   mem_we_i    1 = store, 0 = load
//   mem_addr_i  byte address, bits [1:0] ignored
//   mem_sel_i   byte enables, sel[3] -> data[31:24]
//   mem_data_i  store data
//   mem_data_o  load data, valid with ack (0 otherwise)
//   mem_ack_o   one-cycle completion pulse
//   mem_err_o   out-of-range flag, valid with ack
//   stall_o     combinational stall request: mem_ce_i & ~mem_ack_o
// -----------------------------------------------------------------------------
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ack_o,
  output logic              mem_err_o,
  output logic              stall_o
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam bit               NO_WAIT   = (WAIT_CYCLES == 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;
  logic             err_q;
  logic             load_ok_q;   // ack carries valid RAM read data

  // Latched request (no reset needed, only consumed after acceptance)
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] data_q;

  // Effective request: with zero wait states the RAM is accessed on the
  // accepting edge itself, before the latched copy exists, so in IDLE the
  // live inputs are used; afterwards only the latched copy counts.
  logic              req_idle;
  logic              eff_we;
  logic [DATA_W-1:0] eff_addr;
  logic [SEL_W-1:0]  eff_sel;
  logic [DATA_W-1:0] eff_data;
  logic              eff_oor;
  logic              enter_ack;
  logic [SEL_W-1:0]  ram_be_d;
  logic [ADDR_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rdata;

  assign req_idle = (state_q == S_IDLE);
  assign eff_we   = req_idle ? mem_we_i   : we_q;
  assign eff_addr = req_idle ? mem_addr_i : addr_q;
  assign eff_sel  = req_idle ? mem_sel_i  : sel_q;
  assign eff_data = req_idle ? mem_data_i : data_q;
  assign eff_oor  = addr_out_of_range(eff_addr, ADDR_W);
  assign ram_idx  = eff_addr[ADDR_W+1:2];

  // The edge that moves the FSM into ACK performs the RAM access.
  assign enter_ack = (req_idle && mem_ce_i && NO_WAIT) ||
                     ((state_q == S_WAIT) && mem_ce_i && (cnt_q == CNT_W'(1)));

  // Gated by rst so that no write can slip through while reset is held.
  assign ram_be_d = (enter_ack && eff_we && !eff_oor && rst) ? eff_sel : SEL_NONE;

  data_ram_bytelane #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk       (clk),
    .wr_addr_i (ram_idx),
    .wr_be_i   (ram_be_d),
    .wr_data_i (eff_data),
    .rd_addr_i (ram_idx),
    .rd_data_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      ack_q     <= enter_ack;
      err_q     <= enter_ack && eff_oor;
      load_ok_q <= enter_ack && !eff_we && !eff_oor;
      unique case (state_q)
        S_IDLE: begin
          if (mem_ce_i) begin
            cnt_q   <= WAIT_INIT;
            state_q <= NO_WAIT ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_ce_i) begin
            // Requester withdrew: abort without write or ack.
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= S_ACK;
            end
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_idle && mem_ce_i) begin
      we_q   <= mem_we_i;
      addr_q <= mem_addr_i;
      sel_q  <= mem_sel_i;
      data_q <= mem_data_i;
    end
  end

  // The RAM read register was loaded on the edge entering ACK; it is only
  // exposed during a successful load ack so the bus reads 0 otherwise.
  assign mem_data_o = load_ok_q ? ram_rdata : '0;
  assign mem_ack_o  = ack_q;
  assign mem_err_o  = err_q;
  assign stall_o    = mem_ce_i & ~ack_q;

endmodule
